dma_mp3: RTL and testbench

DMA_MP3 -- requirements
Module: dma_mp3

---
 rtl/dma_mp3_pkg.sv | 41 ++++
 rtl/dma_mp3_fifo.sv | 51 +++++
 rtl/dma_mp3.sv | 221 ++++++++++++++++++++++
 tb/tb_dma_mp3.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_mp3_pkg.sv
// dma_mp3_pkg: shared constants and types for the MP3 streaming DMA.
// Contents: register indices, control/status bit positions, FIFO sizing,
// holdoff length, page boundary pattern and the fetch FSM encoding.
package dma_mp3_pkg;

  localparam int ADDR_W     = 22;
  localparam int FIFO_DEPTH = 4;
  localparam int FIFO_CNT_W = 3;
  localparam int FIFO_PTR_W = 2;

  // Count value at which no further fetch may be issued.
  localparam logic [FIFO_CNT_W-1:0] FIFO_FULL_CNT = 3'd4;

  // Register file indices (regsel).
  localparam logic [1:0] REG_ADDR_LO  = 2'd0;
  localparam logic [1:0] REG_ADDR_MID = 2'd1;
  localparam logic [1:0] REG_ADDR_HI  = 2'd2;
  localparam logic [1:0] REG_CTRL     = 2'd3;

  // Control write bit positions.
  localparam int CTRL_EN_BIT = 0;

  // Status read bit positions.
  localparam int STAT_EN_BIT    = 0;
  localparam int STAT_EMPTY_BIT = 1;
  localparam int STAT_DREQ_BIT  = 2;
  localparam int STAT_PAGE_BIT  = 3;

  // Cycles during which a new start is blocked after each start.
  localparam logic [1:0] HOLDOFF_CYCLES = 2'd2;

  // Low address bits of the last byte of a 16 KiB page.
  localparam logic [13:0] PAGE_LAST = 14'h3FFF;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REQ      = 2'd1,
    ST_WAIT_END = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/dma_mp3_fifo.sv
// dma_mp3_fifo: 4-entry byte FIFO between the DMA fetch side and the SPI feed.
// Ports: clk/rst, push+wdat, pop, flush (clears all entries), rdat (head),
// count (0..4) and empty. Caller never pushes when full nor pops when empty.
module dma_mp3_fifo
  import dma_mp3_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  flush,
  input  logic [7:0]            wdat,
  output logic [7:0]            rdat,
  output logic [FIFO_CNT_W-1:0] count,
  output logic                  empty
);

  logic [7:0]            mem_q [FIFO_DEPTH];
  logic [FIFO_PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [FIFO_CNT_W-1:0] count_q;

  // Storage needs no reset: entries are only read when count says valid.
  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_ptr_q] <= wdat;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign rdat  = mem_q[rd_ptr_q];
  assign count = count_q;
  assign empty = (count_q == '0);

endmodule

// File: rtl/dma_mp3.sv
// dma_mp3: fetches bytes from memory over the DMA bus and feeds the MP3 data
// SPI shifter, paced by the decoder's DREQ. Ports: register file (module_select,
// write_strobe, regsel, din, dout), DMA read master (dma_req/ack/end/rnw/addr/rd),
// SPI feed (md_din, md_start, md_rdy) and md_dreq. Optional DMA_MP3_PAGESTOP_EN
// stops streaming after the byte that completes a 16 KiB page.
module dma_mp3
  import dma_mp3_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              module_select,
  input  logic              write_strobe,
  input  logic [1:0]        regsel,
  input  logic [7:0]        din,
  output logic [7:0]        dout,
  output logic              dma_req,
  input  logic              dma_ack,
  input  logic              dma_end,
  output logic              dma_rnw,
  output logic [ADDR_W-1:0] dma_addr,
  input  logic [7:0]        dma_rd,
  output logic [7:0]        md_din,
  output logic              md_start,
  input  logic              md_rdy,
  input  logic              md_dreq
);

  fetch_state_e          state_q, state_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic                  enable_q, enable_d;
  logic                  discard_q, discard_d;
  logic [2:0]            pend_vld_q, pend_vld_d;
  logic [7:0]            pend_lo_q, pend_lo_d, pend_mid_q, pend_mid_d;
  logic [5:0]            pend_hi_q, pend_hi_d;
  logic [1:0]            holdoff_q, holdoff_d;
  logic                  md_start_q;
  logic [7:0]            md_din_q;
  logic                  dreq_meta_q, dreq_sync_q;

  logic                  wr_en, wr_lo, wr_mid, wr_hi, wr_ctrl, en_clr_wr;
  logic                  push, fire, discard_now, stop_now, page_done;
  logic [7:0]            fifo_rdat, status;
  logic [FIFO_CNT_W-1:0] fifo_count;
  logic                  fifo_empty;

  assign wr_en     = module_select & write_strobe;
  assign wr_lo     = wr_en & (regsel == REG_ADDR_LO);
  assign wr_mid    = wr_en & (regsel == REG_ADDR_MID);
  assign wr_hi     = wr_en & (regsel == REG_ADDR_HI);
  assign wr_ctrl   = wr_en & (regsel == REG_CTRL);
  assign en_clr_wr = wr_ctrl & ~din[CTRL_EN_BIT];

  // A byte already requested when enable was cleared is thrown away on arrival.
  assign discard_now = discard_q | en_clr_wr;
  assign push        = (state_q == ST_WAIT_END) & dma_end & ~discard_now;

  // Start is issued from registers, so md_start/md_din appear one cycle after fire.
  assign fire = ~fifo_empty & dreq_sync_q & md_rdy & (holdoff_q == 2'd0) & ~en_clr_wr;

`ifdef DMA_MP3_PAGESTOP_EN
  logic stop_pend_q, page_done_q;

  // The wrapping ack arms the stop; it fires when that byte is delivered and kept.
  assign stop_now = (state_q == ST_WAIT_END) & dma_end & stop_pend_q & ~discard_now;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stop_pend_q <= 1'b0;
      page_done_q <= 1'b0;
    end else begin
      if (state_q == ST_REQ && dma_ack && addr_q[13:0] == PAGE_LAST)
        stop_pend_q <= 1'b1;
      else if (state_q == ST_WAIT_END && dma_end)
        stop_pend_q <= 1'b0;
      if (wr_ctrl)       page_done_q <= 1'b0;
      else if (stop_now) page_done_q <= 1'b1;
    end
  end
  assign page_done = page_done_q;
`else
  assign stop_now  = 1'b0;
  assign page_done = 1'b0;
`endif

  always_comb begin
    enable_d = enable_q;
    if (stop_now) enable_d = 1'b0;
    if (wr_ctrl)  enable_d = din[CTRL_EN_BIT];
  end

  // Fetch FSM and address update.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    pend_vld_d = pend_vld_q;
    pend_lo_d  = pend_lo_q;
    pend_mid_d = pend_mid_q;
    pend_hi_d  = pend_hi_q;
    discard_d  = discard_q;

    case (state_q)
      ST_IDLE: begin
        if (enable_d && fifo_count < FIFO_FULL_CNT) state_d = ST_REQ;
      end
      ST_REQ: begin
        // An ack wins over a simultaneous disable so the read is tracked to its end.
        if (dma_ack) begin
          state_d = ST_WAIT_END;
          addr_d  = addr_q + 1'b1;
        end else if (!enable_d) begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT_END: begin
        if (dma_end) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (state_d == ST_WAIT_END) begin
      if (en_clr_wr) discard_d = 1'b1;
    end else begin
      discard_d = 1'b0;
    end

    // Address writes landing while dma_req is up are parked so the address
    // seen by the arbiter stays stable; they apply once the request is gone.
    if (state_q != ST_REQ) begin
      if (pend_vld_q[0]) addr_d[7:0]   = pend_lo_q;
      if (pend_vld_q[1]) addr_d[15:8]  = pend_mid_q;
      if (pend_vld_q[2]) addr_d[21:16] = pend_hi_q;
      pend_vld_d = 3'b000;
    end
    if (wr_lo) begin
      if (state_q == ST_REQ) begin pend_vld_d[0] = 1'b1; pend_lo_d = din; end
      else addr_d[7:0] = din;
    end
    if (wr_mid) begin
      if (state_q == ST_REQ) begin pend_vld_d[1] = 1'b1; pend_mid_d = din; end
      else addr_d[15:8] = din;
    end
    if (wr_hi) begin
      if (state_q == ST_REQ) begin pend_vld_d[2] = 1'b1; pend_hi_d = din[5:0]; end
      else addr_d[21:16] = din[5:0];
    end
  end

  always_comb begin
    holdoff_d = holdoff_q;
    if (fire)                   holdoff_d = HOLDOFF_CYCLES;
    else if (holdoff_q != 2'd0) holdoff_d = holdoff_q - 2'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      enable_q    <= 1'b0;
      discard_q   <= 1'b0;
      pend_vld_q  <= 3'b000;
      pend_lo_q   <= 8'h00;
      pend_mid_q  <= 8'h00;
      pend_hi_q   <= 6'h00;
      holdoff_q   <= 2'd0;
      md_start_q  <= 1'b0;
      md_din_q    <= 8'h00;
      dreq_meta_q <= 1'b0;
      dreq_sync_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      enable_q    <= enable_d;
      discard_q   <= discard_d;
      pend_vld_q  <= pend_vld_d;
      pend_lo_q   <= pend_lo_d;
      pend_mid_q  <= pend_mid_d;
      pend_hi_q   <= pend_hi_d;
      holdoff_q   <= holdoff_d;
      md_start_q  <= fire;
      if (fire) md_din_q <= fifo_rdat;
      dreq_meta_q <= md_dreq;
      dreq_sync_q <= dreq_meta_q;
    end
  end

  dma_mp3_fifo u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (fire),
    .flush (en_clr_wr),
    .wdat  (dma_rd),
    .rdat  (fifo_rdat),
    .count (fifo_count),
    .empty (fifo_empty)
  );

  always_comb begin
    status                 = 8'h00;
    status[STAT_EN_BIT]    = enable_q;
    status[STAT_EMPTY_BIT] = fifo_empty;
    status[STAT_DREQ_BIT]  = dreq_sync_q;
    status[STAT_PAGE_BIT]  = page_done;
  end

  always_comb begin
    case (regsel)
      REG_ADDR_LO:  dout = addr_q[7:0];
      REG_ADDR_MID: dout = addr_q[15:8];
      REG_ADDR_HI:  dout = {2'b00, addr_q[21:16]};
      default:      dout = status;
    endcase
  end

  assign dma_req  = (state_q == ST_REQ);
  assign dma_rnw  = 1'b1;
  assign dma_addr = addr_q;
  assign md_start = md_start_q;
  assign md_din   = md_din_q;

endmodule

// File: tb/tb_dma_mp3.sv
// tb_dma_mp3: directed bench for dma_mp3 with a simple DMA bus responder
// and a start monitor; all checks go through check().
module tb_dma_mp3;

  logic        clk = 1'b0;
  logic        rst;
  logic        module_select, write_strobe;
  logic [1:0]  regsel;
  logic [7:0]  din, dout;
  logic        dma_req, dma_ack, dma_end, dma_rnw;
  logic [21:0] dma_addr;
  logic [7:0]  dma_rd, md_din;
  logic        md_start, md_rdy, md_dreq;

  dma_mp3 dut (
    .clk(clk), .rst(rst), .module_select(module_select), .write_strobe(write_strobe),
    .regsel(regsel), .din(din), .dout(dout), .dma_req(dma_req), .dma_ack(dma_ack),
    .dma_end(dma_end), .dma_rnw(dma_rnw), .dma_addr(dma_addr), .dma_rd(dma_rd),
    .md_din(md_din), .md_start(md_start), .md_rdy(md_rdy), .md_dreq(md_dreq)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          cyc      = 0;
  bit          bus_auto = 1'b0;
  logic [7:0]  rd_byte  = 8'h00;
  logic [7:0]  start_dat[$];
  int          start_cyc[$];
  logic [21:0] ack_addr[$];
  int          min_gap;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // Start monitor, sampled 1 time unit after the rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (md_start === 1'b1) begin
        start_dat.push_back(md_din);
        start_cyc.push_back(cyc);
      end
    end
  end

  task automatic bus_responder();
    forever begin
      @(negedge clk);
      if (bus_auto && dma_req === 1'b1) begin
        ack_addr.push_back(dma_addr);
        dma_ack = 1'b1;
        @(negedge clk);
        dma_ack = 1'b0;
        @(negedge clk);
        dma_rd  = rd_byte;
        rd_byte = rd_byte + 8'h01;
        dma_end = 1'b1;
        @(negedge clk);
        dma_end = 1'b0;
      end
    end
  endtask

  task automatic reg_wr(input logic [1:0] r, input logic [7:0] d);
    @(negedge clk);
    module_select = 1'b1; write_strobe = 1'b1; regsel = r; din = d;
    @(negedge clk);
    module_select = 1'b0; write_strobe = 1'b0; regsel = 2'd3;
  endtask

  task automatic reg_rd(input logic [1:0] r, output logic [7:0] d);
    regsel = r;
    #1;
    d = dout;
  endtask

  task automatic man_ack();
    dma_ack = 1'b1;
    @(negedge clk);
    dma_ack = 1'b0;
  endtask

  task automatic man_end(input logic [7:0] d);
    dma_rd = d; dma_end = 1'b1;
    @(negedge clk);
    dma_end = 1'b0;
  endtask

  task automatic wait_req(input int max);
    int i = 0;
    while (dma_req !== 1'b1 && i < max) begin @(negedge clk); i++; end
  endtask

  task automatic wait_starts(input int n, input int max);
    int i = 0;
    while (start_dat.size() < n && i < max) begin @(negedge clk); i++; end
  endtask

  task automatic wait_acks(input int n, input int max);
    int i = 0;
    while (ack_addr.size() < n && i < max) begin @(negedge clk); i++; end
  endtask

  task automatic clear_logs();
    start_dat.delete(); start_cyc.delete(); ack_addr.delete();
  endtask

  task automatic do_reset();
    bus_auto = 1'b0;
    rst = 1'b1;
    module_select = 1'b0; write_strobe = 1'b0; regsel = 2'd3; din = 8'h00;
    dma_ack = 1'b0; dma_end = 1'b0; md_dreq = 1'b0; md_rdy = 1'b1;
    repeat (6) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    clear_logs();
  endtask

  task automatic calc_min_gap(input int n);
    min_gap = 1000;
    for (int i = 1; i < n && i < start_cyc.size(); i++)
      if (start_cyc[i] - start_cyc[i-1] < min_gap) min_gap = start_cyc[i] - start_cyc[i-1];
  endtask

  logic [7:0] rb;

  initial begin
    fork
      bus_responder();
    join_none

    // Reset values, checked while reset is still held.
    rst = 1'b1;
    module_select = 1'b0; write_strobe = 1'b0; regsel = 2'd3; din = 8'h00;
    dma_ack = 1'b0; dma_end = 1'b0; dma_rd = 8'h00; md_dreq = 1'b0; md_rdy = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_dma_req", dma_req, 1'b0);
    check("rst_md_start", md_start, 1'b0);
    check("rst_md_din", md_din, 8'h00);
    check("rst_dma_addr", dma_addr, 22'h0);
    check("rst_dma_rnw", dma_rnw, 1'b1);
    reg_rd(2'd3, rb);
    check("rst_status", rb, 8'h02);
    do_reset();

    // Streaming from 0x012340.
    reg_wr(2'd0, 8'h40);
    reg_wr(2'd1, 8'h23);
    reg_wr(2'd2, 8'hC1);
    reg_rd(2'd0, rb); check("addr_lo_rb", rb, 8'h40);
    reg_rd(2'd1, rb); check("addr_mid_rb", rb, 8'h23);
    reg_rd(2'd2, rb); check("addr_hi_rb", rb, 8'h01);
    md_dreq = 1'b1; rd_byte = 8'hA0; bus_auto = 1'b1;
    reg_wr(2'd3, 8'hFF);
    wait_starts(6, 400);
    check("stream_starts", start_dat.size() >= 6, 1'b1);
    for (int i = 0; i < 6; i++)
      check($sformatf("stream_din%0d", i),
            (i < start_dat.size()) ? 32'(start_dat[i]) : 32'hDEAD, 32'hA0 + i);
    for (int i = 0; i < 4; i++)
      check($sformatf("stream_addr%0d", i),
            (i < ack_addr.size()) ? 32'(ack_addr[i]) : 32'hDEAD, 32'h012340 + i);
    calc_min_gap(6);
    check("stream_gap", min_gap >= 3, 1'b1);

    // Asynchronous reset in the middle of streaming, observed before any edge.
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("arst_dma_req", dma_req, 1'b0);
    check("arst_dma_addr", dma_addr, 22'h0);
    check("arst_md_start", md_start, 1'b0);
    check("arst_md_din", md_din, 8'h00);
    bus_auto = 1'b0;
    repeat (5) @(negedge clk);
    do_reset();

    // Backpressure: DREQ low allows exactly four fetches.
    reg_wr(2'd1, 8'h01);
    rd_byte = 8'h10; bus_auto = 1'b1;
    reg_wr(2'd3, 8'h01);
    repeat (60) @(negedge clk);
    check("bp_fetches", ack_addr.size(), 4);
    check("bp_req_idle", dma_req, 1'b0);
    check("bp_no_start", start_dat.size(), 0);
    reg_rd(2'd3, rb); check("bp_status", rb, 8'h01);
    md_dreq = 1'b1;
    wait_starts(4, 100);
    for (int i = 0; i < 4; i++)
      check($sformatf("bp_din%0d", i),
            (i < start_dat.size()) ? 32'(start_dat[i]) : 32'hDEAD, 32'h10 + i);
    calc_min_gap(4);
    check("bp_gap", min_gap >= 3, 1'b1);
    wait_acks(5, 100);
    check("bp_resume", ack_addr.size() >= 5, 1'b1);
    check("bp_resume_addr", (ack_addr.size() >= 5) ? 32'(ack_addr[4]) : 32'hDEAD, 32'h000104);
    do_reset();

    // Address write during REQ, then disable in WAIT_END.
    reg_wr(2'd1, 8'h02);
    reg_wr(2'd3, 8'h01);
    wait_req(20);
    check("we_req", dma_req, 1'b1);
    reg_wr(2'd0, 8'h80);
    check("we_addr_stable", dma_addr, 22'h000200);
    man_ack();
    @(negedge clk);
    check("we_addr_deferred", dma_addr, 22'h000280);
    reg_wr(2'd3, 8'h00);
    man_end(8'h55);
    repeat (5) @(negedge clk);
    check("we_no_start", start_dat.size(), 0);
    check("we_req_idle", dma_req, 1'b0);
    reg_rd(2'd3, rb); check("we_status", rb, 8'h02);
    md_dreq = 1'b1;
    reg_wr(2'd3, 8'h01);
    wait_req(20);
    check("we_reen_addr", dma_addr, 22'h000280);
    man_ack();
    @(negedge clk);
    man_end(8'h66);
    wait_starts(1, 20);
    check("we_fresh_byte", (start_dat.size() >= 1) ? 32'(start_dat[0]) : 32'hDEAD, 32'h66);
    wait_req(20);
    reg_wr(2'd3, 8'h00);
    check("dis_in_req", dma_req, 1'b0);
    do_reset();

    // 22-bit wrap on ack.
    reg_wr(2'd0, 8'hFF);
    reg_wr(2'd1, 8'hFF);
    reg_wr(2'd2, 8'hFF);
    reg_rd(2'd2, rb); check("wrap_hi_rb", rb, 8'h3F);
    reg_wr(2'd3, 8'h01);
    wait_req(20);
    check("wrap_pre", dma_addr, 22'h3FFFFF);
    man_ack();
    check("wrap_addr", dma_addr, 22'h000000);
    man_end(8'h77);
    do_reset();

    // Page boundary crossing from 0x003FFE.
    reg_wr(2'd0, 8'hFE);
    reg_wr(2'd1, 8'h3F);
    bus_auto = 1'b1;
    reg_wr(2'd3, 8'h01);
    repeat (60) @(negedge clk);
`ifdef DMA_MP3_PAGESTOP_EN
    check("page_fetches", ack_addr.size(), 2);
    reg_rd(2'd3, rb); check("page_status", rb, 8'h08);
    check("page_addr", dma_addr, 22'h004000);
`else
    check("page_fetches", ack_addr.size(), 4);
    check("page_cross_addr", (ack_addr.size() >= 3) ? 32'(ack_addr[2]) : 32'hDEAD, 32'h004000);
    reg_rd(2'd3, rb); check("page_status", rb, 8'h01);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
